// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED-matrix scan controller.
// Holds the per-cell state encoding and the helpers that turn a stored cell
// state into a lit bit.
package led_matrix_pkg;

  typedef enum logic [1:0] {
    CELL_OFF   = 2'b00,
    CELL_ON    = 2'b01,
    CELL_BLINK = 2'b10,
    CELL_RSVD  = 2'b11
  } cell_state_t;

  // The reserved code is kept as "on" so a stray write still lights the cell.
  function automatic cell_state_t cell_store(input logic [1:0] raw);
    cell_state_t s;
    case (raw)
      2'b00:   s = CELL_OFF;
      2'b01:   s = CELL_ON;
      2'b10:   s = CELL_BLINK;
      2'b11:   s = CELL_ON;
      default: s = CELL_OFF;
    endcase
    return s;
  endfunction

  // A blink cell is lit only during the bright half of the blink period.
  function automatic logic cell_lit(input cell_state_t s, input logic phase);
    logic lit;
    case (s)
      CELL_OFF:   lit = 1'b0;
      CELL_ON:    lit = 1'b1;
      CELL_BLINK: lit = phase;
      CELL_RSVD:  lit = 1'b1;
      default:    lit = 1'b0;
    endcase
    return lit;
  endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// Game-logic side of the LED-matrix scanner: cell writes, buffer clear,
// commit request and the commit-pending status.
//   master: game logic (drives writes/clr/commit, reads commit_pending)
//   slave : led_matrix_scanner
interface led_matrix_scanner_if #(
  parameter int ROWS = 7,
  parameter int COLS = 5
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_col;
  logic [1:0]    wr_state;
  logic          clr;
  logic          commit;
  logic          commit_pending;

  modport master (
    output wr_en, wr_row, wr_col, wr_state, clr, commit,
    input  commit_pending
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_state, clr, commit,
    output commit_pending
  );
endinterface

// File: rtl/led_matrix_buffer.sv
// Back and front cell buffers of the LED matrix.
//   wr_en/wr_row/wr_col/wr_state : single-cell write into the back buffer
//   clr                          : clear back buffer (beats a same-cycle write)
//   copy                         : copy the whole back buffer to the front
//   rd_row/phase -> rd_lit       : lit bits of one front-buffer row
// The copy samples the back buffer before any same-cycle write or clear, so
// those land in the back buffer only.
module led_matrix_buffer
  import led_matrix_pkg::*;
#(
  parameter int ROWS = 7,
  parameter int COLS = 5,
  parameter int RW   = 3,
  parameter int CW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [CW-1:0]   wr_col,
  input  logic [1:0]      wr_state,
  input  logic            clr,
  input  logic            copy,
  input  logic [RW-1:0]   rd_row,
  input  logic            phase,
  output logic [COLS-1:0] rd_lit
);

  cell_state_t back_r  [ROWS][COLS];
  cell_state_t front_r [ROWS][COLS];

  // Buffer storage: reset, frame-boundary copy and back-buffer updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          back_r[r][c]  <= CELL_OFF;
          front_r[r][c] <= CELL_OFF;
        end
      end
    end else begin
      if (copy) begin
        front_r <= back_r;
      end
      // Out-of-range addresses match no cell and are dropped.
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (clr) begin
            back_r[r][c] <= CELL_OFF;
          end else if (wr_en && (wr_row == RW'(r)) && (wr_col == CW'(c))) begin
            back_r[r][c] <= cell_store(wr_state);
          end
        end
      end
    end
  end

  // Row read: lit bits of the addressed front-buffer row.
  always_comb begin
    rd_lit = {COLS{1'b0}};
    for (int r = 0; r < ROWS; r++) begin
      if (rd_row == RW'(r)) begin
        for (int c = 0; c < COLS; c++) begin
          rd_lit[c] = cell_lit(front_r[r][c], phase);
        end
      end else begin
        rd_lit = rd_lit;
      end
    end
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered ROWS x COLS LED-matrix scan controller.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : cell writes, clr, commit request, commit_pending status
//   linhas     : one-hot active-low row select (registered)
//   colunas    : active-high column drive for the selected row (registered)
//   frame_tick : one-cycle pulse in the last cycle of each frame (registered)
// Each row is held for SCAN_DIV cycles; a committed back buffer becomes
// visible only at a frame boundary.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS         = 7,
  parameter int COLS         = 5,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  led_matrix_scanner_if.slave  bus,
  output logic [ROWS-1:0]      linhas,
  output logic [COLS-1:0]      colunas,
  output logic                 frame_tick
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_PRE   = SW'(SCAN_DIV - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [SW-1:0]   scan_cnt_r;
  logic [RW-1:0]   row_idx_r;
  logic [BW-1:0]   blink_cnt_r;
  logic            phase_r;
  logic [0:0]      state_r;
  logic [ROWS-1:0] linhas_r;
  logic [COLS-1:0] colunas_r;
  logic            frame_tick_r;

  logic            terminal_s;
  logic            boundary_s;
  logic            copy_s;
  logic [COLS-1:0] lit_s;

  assign terminal_s = (scan_cnt_r == SCAN_LAST);
  assign boundary_s = terminal_s && (row_idx_r == ROW_LAST);
  // A commit landing in the boundary cycle itself is honoured immediately.
  assign copy_s     = boundary_s && ((state_r == ST_PENDING) || bus.commit);

  assign bus.commit_pending = (state_r == ST_PENDING);
  assign linhas             = linhas_r;
  assign colunas            = colunas_r;
  assign frame_tick         = frame_tick_r;

  led_matrix_buffer #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW),
    .CW   (CW)
  ) u_buffer (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_row   (bus.wr_row),
    .wr_col   (bus.wr_col),
    .wr_state (bus.wr_state),
    .clr      (bus.clr),
    .copy     (copy_s),
    .rd_row   (row_idx_r),
    .phase    (phase_r),
    .rd_lit   (lit_s)
  );

  // Scan counter and row index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_r <= {SW{1'b0}};
      row_idx_r  <= {RW{1'b0}};
    end else if (terminal_s) begin
      scan_cnt_r <= {SW{1'b0}};
      if (row_idx_r == ROW_LAST) begin
        row_idx_r <= {RW{1'b0}};
      end else begin
        row_idx_r <= row_idx_r + RW'(1);
      end
    end else begin
      scan_cnt_r <= scan_cnt_r + SW'(1);
    end
  end

  // Blink frame counter and phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_r <= {BW{1'b0}};
      phase_r     <= 1'b0;
    end else if (boundary_s) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= {BW{1'b0}};
        phase_r     <= ~phase_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BW'(1);
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
    end
  end

  // Commit FSM: IDLE until a commit, PENDING until the next frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!boundary_s && bus.commit) begin
            state_r <= ST_PENDING;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PENDING: begin
          if (boundary_s) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_PENDING;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Output registers. frame_tick is raised one cycle early so that the
  // registered pulse coincides with the boundary cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      linhas_r     <= {ROWS{1'b1}};
      colunas_r    <= {COLS{1'b0}};
      frame_tick_r <= 1'b0;
    end else begin
      linhas_r     <= ~({{(ROWS-1){1'b0}}, 1'b1} << row_idx_r);
      colunas_r    <= lit_s;
      frame_tick_r <= (scan_cnt_r == SCAN_PRE) && (row_idx_r == ROW_LAST);
    end
  end

endmodule

// File: doc/led_matrix_scanner.md
# led_matrix_scanner

Parametrised, double-buffered LED-matrix scan controller for the battleship board display. It generalises the fixed 7x5 row/column multiplexing to ROWS x COLS cells with a per-cell state of off, on or blink. Game logic writes cells into a back buffer and requests a commit. The front buffer is swapped in only at a frame boundary, so the display never shows a half-updated board.

## Interface
- ROWS, 7: matrix rows, 2..16
- COLS, 5: matrix columns, 2..16
- SCAN_DIV, 1000: clk cycles each row stays selected, ≥2
- BLINK_FRAMES, 16: full frames per blink half-period, ≥1
- clk  in  1  system clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write one cell of the back buffer this cycle
- wr_row  in  $clog2(ROWS)  row index of the write
- wr_col  in  $clog2(COLS)  column index of the write
- wr_state  in  2  cell state: 00 off, 01 on, 10 blink, 11 reserved (stored as on)
- clr  in  1  clear the whole back buffer to off this cycle
- commit  in  1  pulse; request back→front copy at next frame boundary
- commit_pending  out  1  commit requested but not yet applied
- linhas  out  ROWS  one-hot row select, active-low
- colunas  out  COLS  column drive for the selected row, active-high
- frame_tick  out  1  one-cycle pulse when a full frame completes

## Operation
- Reset values: linhas all ones, colunas zero, frame_tick 0, commit_pending 0. Both buffers all off; scan counter, row index and blink counter 0; blink phase 0 (blink cells dark).
- Scan counter counts 0..SCAN_DIV-1. On its terminal count the row index advances and wraps from ROWS-1 to 0.
- Frame boundary: terminal count while row index = ROWS-1. frame_tick pulses in that cycle.
- Commit:
  - A commit pulse sets commit_pending.
  - At the next frame boundary the whole back buffer is copied to the front buffer and commit_pending clears, both in that same cycle.
  - Further commit pulses while pending are absorbed.
  - A commit arriving in the boundary cycle itself is applied at that boundary.
- Back-buffer writes:
  - Writes with an out-of-range row or column are ignored.
  - clr and wr_en in the same cycle: clr wins and the write is lost.
  - A write or clr in the boundary cycle is not part of that copy; it lands in the back buffer only.
- Blink: the blink counter counts frames 0..BLINK_FRAMES-1; the phase toggles on wrap.
- Cell lit = (state on) or (state blink and phase 1).
- Back buffer is never displayed directly.

## Timing
- linhas and colunas are registered and update together on the clock edge after a row change, so there is no row/column skew. Latency from row index change to pins is 1 cycle.
- A front-buffer update first appears on the pins for row 0 one cycle after the boundary.
- Worst-case write-to-display latency: ROWS·SCAN_DIV + 1 cycles after commit.
- rst asserted mid-frame: all state returns to reset values immediately. Scan restarts at row 0 after rst deasserts; a pending commit is discarded.
- Frame period: ROWS·SCAN_DIV cycles. Blink period: 2·BLINK_FRAMES frames.

## Structure
- Package led_matrix_pkg holds:
  - the cell-state encodings (CELL_OFF, CELL_ON, CELL_BLINK, CELL_RSVD) and their typedef;
  - a function mapping a cell state plus blink phase to a lit bit.
- Sub-module led_matrix_buffer holds the back and front buffers. Ports: write, clr, copy, row-read; output is a COLS-wide lit vector for the addressed row, plus the phase input.
- led_matrix_scanner holds the counters, commit FSM (IDLE / PENDING) and output registers.

## Test plan
- Reset, with ROWS=7, COLS=5, SCAN_DIV=4: linhas=7'b1111111 and colunas=0 during reset. First frame: linhas walks 1111110 → … → 0111111, 4 cycles each; frame_tick every 28 cycles.
- Write (2,3)=on, commit: commit_pending=1 until the boundary. During row 2 of the following frame, colunas=5'b01000; all other rows read 0.
- Write (0,0)=blink, BLINK_FRAMES=1, commit: colunas bit0 for row 0 alternates 0,1 on successive frames.
- clr and wr_en (1,1)=on in the same cycle, then commit: the next frame is all dark.
- Write to row 7 (out of range), commit: display unchanged. Write in the boundary cycle: absent from that copy, present after the next commit.
- rst pulsed mid-row 4 with commit pending: outputs return to reset values, commit_pending=0, and the scan resumes at row 0.
